// File: rtl/alu_pkg.sv
// Shared definitions for the operand-entry front end and the 4-bit ALU:
// opcode encodings, entry FSM state encoding and the stage code mapping.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_CMP = 3'b110,
        OP_EQ  = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        S_A    = 3'b000,
        S_B    = 3'b001,
        S_OP   = 3'b010,
        S_EXEC = 3'b011,
        S_SHOW = 3'b100
    } state_e;

    localparam logic [1:0] STAGE_A    = 2'b00;
    localparam logic [1:0] STAGE_B    = 2'b01;
    localparam logic [1:0] STAGE_OP   = 2'b10;
    localparam logic [1:0] STAGE_SHOW = 2'b11;

    // EXEC and SHOW share one stage code because both present a result.
    function automatic logic [1:0] stage_of(state_e s);
        case (s)
            S_A:     return STAGE_A;
            S_B:     return STAGE_B;
            S_OP:    return STAGE_OP;
            default: return STAGE_SHOW;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, counting debouncer and a
// one-cycle press pulse on each accepted 0->1 transition. After reset the
// pulse stays disarmed until the button has been seen released, so a button
// held through reset never produces a stray press.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             valid1_q, valid1_d;
    logic             valid2_q, valid2_d;
    logic             armed_q, armed_d;
    logic             deb_q, deb_d;
    logic             deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Next-state logic: the level flips only after DEB_CYCLES consecutive
    // disagreeing samples; the pulse fires one cycle after the rising flip.
    always_comb begin
        sync1_d    = btn;
        sync2_d    = sync1_q;
        valid1_d   = 1'b1;
        valid2_d   = valid1_q;
        armed_d    = armed_q | (valid2_q & ~sync2_q);
        deb_d      = deb_q;
        cnt_d      = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        deb_prev_d = deb_q;
        press_d    = armed_q & deb_q & ~deb_prev_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            valid1_q   <= 1'b0;
            valid2_q   <= 1'b0;
            armed_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            valid1_q   <= valid1_d;
            valid2_q   <= valid2_d;
            armed_q    <= armed_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alu_entry.sv
// Button-driven operand/opcode entry for a 4-bit ALU: each press latches the
// next field, one EXEC cycle captures the ALU result, SHOW displays it.
module alu_entry
    import alu_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic [3:0] sw,
    input  logic [2:0] sw_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_res,
    output logic [3:0] disp_val,
    output logic [1:0] stage,
    output logic       res_valid,
    output logic [7:0] op_cnt
);

    logic       press;

    state_e     state_q, state_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    alu_op_e    alu_op_q, alu_op_d;
    logic [3:0] res_q, res_d;
    logic [7:0] op_cnt_q, op_cnt_d;
    logic [1:0] stage_q, stage_d;
    logic       res_valid_q, res_valid_d;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .press (press)
    );

    // Entry sequencing: presses advance A -> B -> OP, EXEC is a single
    // capture cycle, and a press in SHOW returns to A keeping old operands.
    always_comb begin
        state_d  = state_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        res_d    = res_q;
        op_cnt_d = op_cnt_q;
        case (state_q)
            S_A: begin
                if (press) begin
                    alu_a_d = sw;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (press) begin
                    alu_b_d = sw;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (press) begin
                    alu_op_d = alu_op_e'(sw_op);
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d    = alu_res;
                op_cnt_d = op_cnt_q + 8'd1;
                state_d  = S_SHOW;
            end
            S_SHOW: begin
                if (press) begin
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
        stage_d     = stage_of(state_d);
        res_valid_d = (state_d == S_SHOW);
    end

    // Registered FSM state and outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_A;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_ADD;
            res_q       <= '0;
            op_cnt_q    <= '0;
            stage_q     <= STAGE_A;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_q       <= res_d;
            op_cnt_q    <= op_cnt_d;
            stage_q     <= stage_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Display mux: live switches while entering, the result once computed.
    always_comb begin
        case (state_q)
            S_A, S_B: disp_val = sw;
            S_OP:     disp_val = {1'b0, sw_op};
            default:  disp_val = res_q;
        endcase
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign stage     = stage_q;
    assign res_valid = res_valid_q;
    assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_alu_entry.sv
// Bench for alu_entry with DEB_CYCLES=4: a history-based reference model is
// checked against the DUT every cycle, plus directed literal expectations.
module tb_alu_entry;
    import alu_pkg::*;

    localparam int DEB  = 4;
    localparam int HOLD = DEB + 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic [3:0] sw;
    logic [2:0] sw_op;
    logic [3:0] alu_a, alu_b, alu_res, disp_val;
    logic [2:0] alu_op;
    logic [1:0] stage;
    logic       res_valid;
    logic [7:0] op_cnt;

    int compared   = 0;
    int mismatched = 0;

    alu_entry #(
        .DEB_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .sw        (sw),
        .sw_op     (sw_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .disp_val  (disp_val),
        .stage     (stage),
        .res_valid (res_valid),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    // Bench-side ALU in plain integer arithmetic.
    function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        case (op)
            OP_ADD:  return 4'((ia + ib) % 16);
            OP_SUB:  return 4'((ia - ib + 16) % 16);
            OP_NOT:  return 4'(15 - ia);
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_CMP:  return (ia > ib) ? 4'd1 : 4'd0;
            default: return (ia == ib) ? 4'd1 : 4'd0;
        endcase
    endfunction

    always_comb alu_res = ref_alu(alu_a, alu_b, alu_op);

    // Reference model: button samples per edge, FSM as plain integers.
    bit hist[$];
    int last_rst = 0;
    bit m_level, m_armed, m_rose, m_pulse;
    int m_state;
    int m_a, m_b, m_op, m_res, m_cnt;
    bit model_ok = 1'b0;

    function automatic bit sync_at(input int m);
        if (m - 2 >= last_rst + 1) return hist[m-2];
        return 1'b0;
    endfunction

    function automatic void model_step();
        int n;
        bit all_diff;
        bit new_pulse;
        bit new_armed;
        n = hist.size();
        if (!rst_n) begin
            last_rst = n;
            m_level  = 0;
            m_armed  = 0;
            m_rose   = 0;
            m_pulse  = 0;
            m_state  = 0;
            m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_cnt = 0;
        end else begin
            new_pulse = m_armed && m_rose;
            new_armed = m_armed || ((n - 2 >= last_rst + 1) && (sync_at(n) == 1'b0));
            all_diff  = 1;
            for (int j = 0; j < DEB; j++) begin
                if ((n - j <= last_rst) || (sync_at(n - j) == m_level)) all_diff = 0;
            end
            case (m_state)
                0: if (m_pulse) begin m_a = int'(sw); m_state = 1; end
                1: if (m_pulse) begin m_b = int'(sw); m_state = 2; end
                2: if (m_pulse) begin m_op = int'(sw_op); m_state = 3; end
                3: begin
                    m_res   = int'(ref_alu(4'(m_a), 4'(m_b), 3'(m_op)));
                    m_cnt   = (m_cnt + 1) % 256;
                    m_state = 4;
                end
                default: if (m_pulse) m_state = 0;
            endcase
            m_rose  = all_diff && !m_level;
            if (all_diff) m_level = !m_level;
            m_armed = new_armed;
            m_pulse = new_pulse;
        end
        hist.push_back(btn);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance it for the next edge.
    always @(negedge clk) begin
        if (model_ok) begin
            checkOutput("m_alu_a", int'(alu_a), m_a);
            checkOutput("m_alu_b", int'(alu_b), m_b);
            checkOutput("m_alu_op", int'(alu_op), m_op);
            checkOutput("m_stage", int'(stage), (m_state >= 3) ? 3 : m_state);
            checkOutput("m_res_valid", int'(res_valid), (m_state == 4) ? 1 : 0);
            checkOutput("m_op_cnt", int'(op_cnt), m_cnt);
            checkOutput("m_disp_val", int'(disp_val),
                        (m_state <= 1) ? int'(sw) : (m_state == 2) ? int'(sw_op) : m_res);
        end
        model_step();
        model_ok = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One clean press: hold long enough to debounce, then release fully.
    task automatic applyStimulus(input logic [3:0] s, input logic [2:0] o);
        tick(1);
        sw    = s;
        sw_op = o;
        btn   = 1'b1;
        tick(HOLD);
        btn   = 1'b0;
        tick(HOLD);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        btn   = 1'b0;
        sw    = 4'd3;
        sw_op = 3'd0;
        tick(3);
        rst_n = 1'b1;

        // Press timing: btn sampled high at cycle 10, pulse at 16, stage at 17.
        tick(10);
        btn = 1'b1;
        tick(6);
        @(negedge clk);
        checkOutput("c15_stage", int'(stage), 0);
        tick(1);
        @(negedge clk);
        checkOutput("c16_stage", int'(stage), 0);
        tick(1);
        @(negedge clk);
        checkOutput("c17_stage", int'(stage), 1);
        checkOutput("c17_alu_a", int'(alu_a), 3);
        tick(1);
        btn = 1'b0;
        tick(HOLD);

        // Bouncing every 2 cycles must never be accepted.
        for (int i = 0; i < 20; i++) begin
            btn = ~btn;
            tick(2);
        end
        tick(HOLD);
        @(negedge clk);
        checkOutput("bounce_stage", int'(stage), 1);

        // 3 + 5 with exactly one EXEC cycle before SHOW.
        applyStimulus(4'd5, 3'd0);
        @(negedge clk);
        checkOutput("b_stage", int'(stage), 2);
        checkOutput("b_alu_b", int'(alu_b), 5);
        tick(1);
        sw_op = 3'b000;
        btn   = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (stage == 2'b11) found = 1'b1;
        end
        if (!found) begin
            checkOutput("exec_timeout", 0, 1);
        end else begin
            checkOutput("exec_res_valid", int'(res_valid), 0);
            @(negedge clk);
            checkOutput("show_res_valid", int'(res_valid), 1);
            checkOutput("add_disp", int'(disp_val), 8);
            checkOutput("add_op_cnt", int'(op_cnt), 1);
        end
        tick(1);
        btn = 1'b0;
        tick(HOLD);

        // 2 - 7 wraps to 4'hB.
        applyStimulus(4'd0, 3'd0);
        applyStimulus(4'd2, 3'd0);
        applyStimulus(4'd7, 3'd0);
        applyStimulus(4'd0, 3'b001);
        @(negedge clk);
        checkOutput("sub_disp", int'(disp_val), 11);
        checkOutput("sub_res_valid", int'(res_valid), 1);
        checkOutput("sub_op_cnt", int'(op_cnt), 2);

        // Reset in S_OP with btn held through and after reset.
        applyStimulus(4'd0, 3'd0);
        applyStimulus(4'd9, 3'd0);
        applyStimulus(4'd6, 3'd0);
        tick(1);
        sw_op = 3'd5;
        btn   = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_stage", int'(stage), 0);
        checkOutput("rst_alu_a", int'(alu_a), 0);
        checkOutput("rst_alu_b", int'(alu_b), 0);
        checkOutput("rst_alu_op", int'(alu_op), 0);
        checkOutput("rst_op_cnt", int'(op_cnt), 0);
        checkOutput("rst_res_valid", int'(res_valid), 0);
        tick(30);
        @(negedge clk);
        checkOutput("held_stage", int'(stage), 0);
        tick(1);
        btn = 1'b0;
        tick(HOLD);
        applyStimulus(4'd1, 3'd0);
        @(negedge clk);
        checkOutput("repress_stage", int'(stage), 1);
        checkOutput("repress_alu_a", int'(alu_a), 1);

        // 256 operations wrap op_cnt back to 0.
        applyStimulus(4'd2, 3'd0);
        applyStimulus(4'd0, 3'b011);
        for (int i = 1; i < 256; i++) begin
            applyStimulus(4'd0, 3'd0);
            applyStimulus(4'(i), 3'd0);
            applyStimulus(4'(i * 3), 3'd0);
            applyStimulus(4'd0, 3'(i));
            if (i == 254) begin
                @(negedge clk);
                checkOutput("cnt_255", int'(op_cnt), 255);
            end
        end
        @(negedge clk);
        checkOutput("cnt_wrap", int'(op_cnt), 0);
        checkOutput("wrap_res_valid", int'(res_valid), 1);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
